// File: rtl/wmem_stream_reader.sv
// Read-side burst master for the weight memory wrapper. Accepts a (base, length)
// command, issues back-to-back single-cycle-latency reads and streams the words
// through a credit-limited output FIFO so backpressure never drops a word.
module wmem_stream_reader #(
    parameter int unsigned DATA_BIT        = 128,
    parameter int unsigned WMEM_DEPTH      = 1536,
    parameter int unsigned WMEM_ADDR_WIDTH = $clog2(WMEM_DEPTH),
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [WMEM_ADDR_WIDTH-1:0] cmd_base,
    input  logic [WMEM_ADDR_WIDTH:0]   cmd_len,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       cmd_err,
    output logic [WMEM_ADDR_WIDTH-1:0] wmem_addr,
    output logic                       wmem_ren,
    input  logic [DATA_BIT-1:0]        wmem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_BIT-1:0]        out_data,
    output logic                       out_last
);

    localparam int unsigned AW = WMEM_ADDR_WIDTH;
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = AW + 2;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              done_d;
    logic              cmd_err_d;

    logic [AW-1:0]     issue_ptr;
    logic [LW-1:0]     issue_left;
    logic              inflight;
    logic              inflight_last;

    logic [DATA_BIT-1:0] fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     fifo_count;

    logic              accept;
    logic [SW-1:0]     cmd_end;
    logic              cmd_bad;
    logic              credit_ok;
    logic              flush;
    logic              push;
    logic              pop;
    logic              last_hs;

    // Command decode, credit check and stream handshakes
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_FETCH);
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_end   = SW'(cmd_base) + SW'(cmd_len);
    assign cmd_bad   = (cmd_len == '0) || (cmd_end > SW'(WMEM_DEPTH));
    assign credit_ok = ((CW + 1)'(fifo_count) + (CW + 1)'(inflight)) < (CW + 1)'(FIFO_DEPTH);
    assign wmem_ren  = busy && (issue_left != '0) && credit_ok && !abort;
    assign wmem_addr = issue_ptr;
    assign flush     = busy && abort;
    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_last  = fifo_last[rd_ptr];
    assign push      = inflight && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign last_hs   = pop && out_last;

    // State register plus the registered done / cmd_err pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            done    <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
            cmd_err <= cmd_err_d;
        end
    end

    // Next-state and pulse decode; abort wins over a coincident last handshake
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        cmd_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_bad) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (last_hs) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Issue pointer, remaining-word counter and in-flight read tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_ptr     <= '0;
            issue_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            if (accept && !cmd_bad) begin
                issue_ptr  <= cmd_base;
                issue_left <= cmd_len;
            end else if (flush) begin
                issue_left <= '0;
            end else if (wmem_ren) begin
                issue_ptr  <= issue_ptr + AW'(1);
                issue_left <= issue_left - LW'(1);
            end
            inflight      <= wmem_ren;
            inflight_last <= wmem_ren && (issue_left == LW'(1));
        end
    end

    // Output FIFO; an abort flushes it and discards the stale in-flight word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_data[i] <= '0;
            end
            fifo_last  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= wmem_rdata;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_wmem_stream_reader.sv
// Bench for wmem_stream_reader: a wrapper memory model, a burst-level scoreboard
// and directed plus randomized command / backpressure / abort stimulus.
module tb_wmem_stream_reader;

    localparam int DEPTH = 1536;
    localparam int FD    = 4;
    localparam logic [127:0] GARBAGE = {4{32'hDEAD_BEEF}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [10:0]  cmd_base;
    logic [11:0]  cmd_len;
    logic         abort;
    logic         busy;
    logic         done;
    logic         cmd_err;
    logic [10:0]  wmem_addr;
    logic         wmem_ren;
    logic [127:0] wmem_rdata;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;

    wmem_stream_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_base   (cmd_base),
        .cmd_len    (cmd_len),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .cmd_err    (cmd_err),
        .wmem_addr  (wmem_addr),
        .wmem_ren   (wmem_ren),
        .wmem_rdata (wmem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-cycle-latency wrapper model; garbage on idle cycles exposes bogus pushes
    logic [127:0] mem [DEPTH];
    always @(posedge clk) begin
        if (wmem_ren) wmem_rdata <= mem[wmem_addr];
        else          wmem_rdata <= GARBAGE;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state
    bit           m_busy;
    int           m_addr;
    int           m_left;
    int           m_outstanding;
    bit           m_exp_done;
    bit           m_exp_err;
    bit           m_chk_flush;
    logic [127:0] q_data [$];
    bit           q_last [$];

    // Event logs for directed timing checks
    int ren_cnt, hs_cnt, done_cnt, err_cnt, acc_cyc;
    int ren_cyc [$];
    int ren_adr [$];
    int hs_cyc  [$];
    int done_cyc[$];

    bit mon_hs, mon_exp_ren, mon_nd, mon_ne, mon_nf, mon_last;
    int mon_end;

    // Cycle monitor: compares the DUT against the burst-level model each cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_left = 0; m_outstanding = 0;
            m_exp_done = 0; m_exp_err = 0; m_chk_flush = 0;
            q_data.delete(); q_last.delete();
        end else begin
            chk("cmd_ready", cmd_ready, !m_busy);
            chk("busy", busy, m_busy);
            chk("done", done, m_exp_done);
            chk("cmd_err", cmd_err, m_exp_err);
            if (m_chk_flush) chk("flush_valid", out_valid, 1'b0);
            if (done) begin done_cnt++; done_cyc.push_back(cyc); end
            if (cmd_err) err_cnt++;
            mon_nd = 0; mon_ne = 0; mon_nf = 0;
            mon_hs = out_valid && out_ready;
            if (mon_hs) begin hs_cnt++; hs_cyc.push_back(cyc); end
            if (wmem_ren) begin ren_cnt++; ren_cyc.push_back(cyc); ren_adr.push_back(int'(wmem_addr)); end
            if (m_busy) begin
                mon_exp_ren = !abort && (m_left > 0) && (m_outstanding < FD);
                chk("ren", wmem_ren, mon_exp_ren);
                if (mon_exp_ren) begin
                    if (wmem_ren) chk("addr", wmem_addr, m_addr);
                    m_addr++; m_left--; m_outstanding++;
                end
                if (mon_hs) begin
                    if (q_data.size() == 0) begin
                        chk("extra_word", 1'b1, 1'b0);
                    end else begin
                        chk("data", out_data, q_data.pop_front());
                        mon_last = q_last.pop_front();
                        chk("last", out_last, mon_last);
                        m_outstanding--;
                        if (mon_last && !abort) begin mon_nd = 1; m_busy = 0; end
                    end
                end
                if (abort) begin
                    q_data.delete(); q_last.delete();
                    m_busy = 0; m_left = 0; m_outstanding = 0; mon_nf = 1;
                end
            end else begin
                chk("idle_ren", wmem_ren, 1'b0);
                chk("idle_valid", out_valid, 1'b0);
                if (cmd_valid) begin
                    acc_cyc = cyc;
                    mon_end = int'(cmd_base) + int'(cmd_len);
                    if (cmd_len == 0 || mon_end > DEPTH) begin
                        mon_ne = 1;
                    end else begin
                        m_busy = 1; m_addr = int'(cmd_base); m_left = int'(cmd_len);
                        m_outstanding = 0;
                        for (int i = int'(cmd_base); i < mon_end; i++) begin
                            q_data.push_back(mem[i]);
                            q_last.push_back(i == mon_end - 1);
                        end
                    end
                end
            end
            m_exp_done = mon_nd; m_exp_err = mon_ne; m_chk_flush = mon_nf;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clr_log();
        ren_cnt = 0; hs_cnt = 0; done_cnt = 0; err_cnt = 0;
        ren_cyc.delete(); ren_adr.delete(); hs_cyc.delete(); done_cyc.delete();
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget && m_busy; i++) tick();
        if (m_busy) chk("timeout_idle", 1'b1, 1'b0);
        repeat (2) tick();
    endtask

    task automatic send_cmd(input int b, input int l);
        int i;
        for (i = 0; i < 200 && m_busy; i++) tick();
        if (m_busy) chk("timeout_send", 1'b1, 1'b0);
        cmd_valid = 1'b1; cmd_base = 11'(b); cmd_len = 12'(l);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cmd_err", cmd_err, 1'b0);
        chk("rst_ren", wmem_ren, 1'b0);
        chk("rst_addr", wmem_addr, 11'd0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_data", out_data, 128'd0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

    initial begin
        int b, l, r, i;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0;
        abort = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) mem[k] = 128'(k);
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a burst
        send_cmd(0, 16);
        repeat (5) tick();
        rst_n = 1'b0;
        #2;
        check_reset_vals();
        tick(); tick();
        rst_n = 1'b1;
        chk("rel_cmd_ready", cmd_ready, 1'b1);
        tick();

        // Basic burst latency and throughput
        clr_log();
        send_cmd(0, 4);
        wait_idle(100);
        chk("t2_ren_cnt", ren_cnt, 4);
        chk("t2_ren_first", ren_cyc[0], acc_cyc + 1);
        chk("t2_ren_final", ren_cyc[3], acc_cyc + 4);
        chk("t2_hs_first", hs_cyc[0], acc_cyc + 3);
        chk("t2_hs_cnt", hs_cnt, 4);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_done_cyc", done_cyc[0], acc_cyc + 7);

        // Bank crossing without a bubble
        clr_log();
        send_cmd(510, 4);
        wait_idle(100);
        for (int k = 0; k < 4; k++) chk("t3_addr", ren_adr[k], 510 + k);
        chk("t3_no_gap", ren_cyc[3] - ren_cyc[0], 3);

        // Backpressure: credits cap reads at the FIFO depth
        clr_log();
        out_ready = 1'b0;
        send_cmd(0, 16);
        repeat (20) tick();
        chk("t4_ren_stall", ren_cnt, FD);
        chk("t4_ren_now", wmem_ren, 1'b0);
        chk("t4_valid_held", out_valid, 1'b1);
        out_ready = 1'b1;
        wait_idle(200);
        chk("t4_hs_cnt", hs_cnt, 16);
        chk("t4_ren_cnt", ren_cnt, 16);
        chk("t4_done_cnt", done_cnt, 1);

        // Illegal commands and upper-boundary legal ones
        clr_log();
        send_cmd(1530, 8);
        repeat (3) tick();
        send_cmd(7, 0);
        repeat (3) tick();
        chk("t5_err_cnt", err_cnt, 2);
        chk("t5_ren_cnt", ren_cnt, 0);
        chk("t5_done_cnt", done_cnt, 0);
        clr_log();
        send_cmd(1532, 4);
        wait_idle(100);
        for (int k = 0; k < 4; k++) chk("t5_addr", ren_adr[k], 1532 + k);
        chk("t5_legal_done", done_cnt, 1);
        chk("t5_legal_err", err_cnt, 0);
        clr_log();
        send_cmd(1535, 1);
        wait_idle(100);
        chk("t5_one_hs", hs_cnt, 1);
        chk("t5_one_done", done_cnt, 1);

        // Abort after the fifth handshake, then a clean follow-up burst
        clr_log();
        send_cmd(0, 16);
        for (i = 0; i < 100 && hs_cnt < 5; i++) tick();
        chk("t6_reach5", hs_cnt >= 5, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (5) tick();
        chk("t6_no_done", done_cnt, 0);
        chk("t6_idle", busy, 1'b0);
        clr_log();
        send_cmd(100, 2);
        wait_idle(100);
        chk("t6_next_hs", hs_cnt, 2);
        chk("t6_next_addr", ren_adr[0], 100);
        chk("t6_next_done", done_cnt, 1);

        // Randomized commands, backpressure and aborts against random contents
        for (int k = 0; k < DEPTH; k++) mem[k] = {$urandom, $urandom, $urandom, $urandom};
        clr_log();
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 9));
            b = int'($urandom_range(0, DEPTH - 1));
            if (r == 2) b = int'($urandom_range(DEPTH - 40, DEPTH - 1));
            if (r == 0)      l = 0;
            else if (r == 1) l = DEPTH + 1 - b + int'($urandom_range(0, 20));
            else             l = int'($urandom_range(1, (DEPTH - b < 40) ? DEPTH - b : 40));
            cmd_base  = 11'(b);
            cmd_len   = 12'(l);
            cmd_valid = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 9) < 7);
            abort     = ($urandom_range(0, 29) == 0);
            tick();
        end
        cmd_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
        wait_idle(300);
        chk("rand_activity", (done_cnt > 10) && (err_cnt > 5), 1'b1);
        chk("rand_drained", out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
